// File: rtl/egg_timer_ctrl.sv
// Egg timer countdown sequencer: BCD MM:SS countdown with start/pause, clear and a
// timed alarm, paced by an internal prescaler that yields one tick per second of clk_in.
module egg_timer_ctrl #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       inc_min,
    input  logic       inc_sec,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state,
    output logic       running,
    output logic       alarm,
    output logic       tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int ALM_W = $clog2(ALARM_SECS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_SECS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_ALARM = 3'd3
    } state_e;

    state_e state_q, state_d;
    logic [3:0] minTens_q, minTens_d, minOnes_q, minOnes_d;
    logic [3:0] secTens_q, secTens_d, secOnes_q, secOnes_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [ALM_W-1:0] almCnt_q, almCnt_d;
    logic running_q, running_d, alarm_q, alarm_d, tick_q, tick_d;

    logic [3:0] decMinTens, decMinOnes, decSecTens, decSecOnes;
    logic [3:0] incMinTens, incMinOnes, incSecTens, incSecOnes;
    logic timeZero, timeOne, wrap;

    assign timeZero = ({minTens_q, minOnes_q, secTens_q, secOnes_q} == 16'h0000);
    assign timeOne  = ({minTens_q, minOnes_q, secTens_q, secOnes_q} == 16'h0001);
    assign wrap     = ((state_q == S_RUN) || (state_q == S_ALARM)) && (presc_q == CNT_LAST);

    // One-second BCD decrement with borrow through every digit; 00:00 stays put.
    always_comb begin
        decMinTens = minTens_q;
        decMinOnes = minOnes_q;
        decSecTens = secTens_q;
        decSecOnes = secOnes_q;
        if (secOnes_q != 4'd0) begin
            decSecOnes = secOnes_q - 4'd1;
        end else if (secTens_q != 4'd0) begin
            decSecOnes = 4'd9;
            decSecTens = secTens_q - 4'd1;
        end else if (minOnes_q != 4'd0) begin
            decSecTens = 4'd5;
            decSecOnes = 4'd9;
            decMinOnes = minOnes_q - 4'd1;
        end else if (minTens_q != 4'd0) begin
            decSecTens = 4'd5;
            decSecOnes = 4'd9;
            decMinOnes = 4'd9;
            decMinTens = minTens_q - 4'd1;
        end
    end

    // Setting increments wrap inside their own field: seconds 59->00, minutes 99->00.
    always_comb begin
        incSecOnes = (secOnes_q == 4'd9) ? 4'd0 : secOnes_q + 4'd1;
        incSecTens = secTens_q;
        if (secOnes_q == 4'd9) begin
            incSecTens = (secTens_q == 4'd5) ? 4'd0 : secTens_q + 4'd1;
        end
        incMinOnes = (minOnes_q == 4'd9) ? 4'd0 : minOnes_q + 4'd1;
        incMinTens = minTens_q;
        if (minOnes_q == 4'd9) begin
            incMinTens = (minTens_q == 4'd9) ? 4'd0 : minTens_q + 4'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        minTens_d = minTens_q;
        minOnes_d = minOnes_q;
        secTens_d = secTens_q;
        secOnes_d = secOnes_q;
        presc_d   = presc_q;
        almCnt_d  = almCnt_q;
        tick_d    = 1'b0;

        if (clear) begin
            state_d   = S_IDLE;
            minTens_d = 4'd0;
            minOnes_d = 4'd0;
            secTens_d = 4'd0;
            secOnes_d = 4'd0;
            presc_d   = '0;
            almCnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    presc_d = '0;
                    if (inc_min) begin
                        minTens_d = incMinTens;
                        minOnes_d = incMinOnes;
                    end
                    if (inc_sec) begin
                        secTens_d = incSecTens;
                        secOnes_d = incSecOnes;
                    end
                    if (start_stop && !timeZero) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    presc_d = wrap ? '0 : presc_q + CNT_W'(1);
                    tick_d  = wrap;
                    // Reaching 00:00 outranks a simultaneous pause request.
                    if (wrap) begin
                        minTens_d = decMinTens;
                        minOnes_d = decMinOnes;
                        secTens_d = decSecTens;
                        secOnes_d = decSecOnes;
                    end
                    if (wrap && timeOne) begin
                        state_d  = S_ALARM;
                        almCnt_d = '0;
                    end else if (start_stop) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start_stop) begin
                        state_d = S_RUN;
                    end
                end
                S_ALARM: begin
                    presc_d = wrap ? '0 : presc_q + CNT_W'(1);
                    tick_d  = wrap;
                    if (start_stop) begin
                        state_d  = S_IDLE;
                        almCnt_d = '0;
                        presc_d  = '0;
                    end else if (wrap) begin
                        if (almCnt_q == ALM_LAST) begin
                            state_d  = S_IDLE;
                            almCnt_d = '0;
                        end else begin
                            almCnt_d = almCnt_q + ALM_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        running_d = (state_d == S_RUN);
        alarm_d   = (state_d == S_ALARM);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            minTens_q <= 4'd0;
            minOnes_q <= 4'd0;
            secTens_q <= 4'd0;
            secOnes_q <= 4'd0;
            presc_q   <= '0;
            almCnt_q  <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            minTens_q <= minTens_d;
            minOnes_q <= minOnes_d;
            secTens_q <= secTens_d;
            secOnes_q <= secOnes_d;
            presc_q   <= presc_d;
            almCnt_q  <= almCnt_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
            tick_q    <= tick_d;
        end
    end

    assign min_tens = minTens_q;
    assign min_ones = minOnes_q;
    assign sec_tens = secTens_q;
    assign sec_ones = secOnes_q;
    assign state    = state_q;
    assign running  = running_q;
    assign alarm    = alarm_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl with a 4-cycle second and a 3-tick alarm;
// each scenario task drives its stimulus and checks the hand-derived results inline.
module tb_egg_timer_ctrl;

    logic       clk_in;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       inc_min;
    logic       inc_sec;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;
    logic       running, alarm, tick;

    int checks = 0;
    int errors = 0;

    wire [15:0] disp = {min_tens, min_ones, sec_tens, sec_ones};

    egg_timer_ctrl #(
        .TICK_DIV  (4),
        .ALARM_SECS(3)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .start_stop(start_stop),
        .clear     (clear),
        .inc_min   (inc_min),
        .inc_sec   (inc_sec),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .state     (state),
        .running   (running),
        .alarm     (alarm),
        .tick      (tick)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change on the falling edge, so each stimulus task returns on the
    // falling edge right after the rising edge that consumed it.
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic pulse_start();
        @(negedge clk_in);
        start_stop = 1'b1;
        @(negedge clk_in);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk_in);
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
    endtask

    task automatic hold_inc(input logic doMin, input logic doSec, input int n);
        @(negedge clk_in);
        inc_min = doMin;
        inc_sec = doSec;
        repeat (n) @(negedge clk_in);
        inc_min = 1'b0;
        inc_sec = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({disp, state, running, alarm, tick} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got disp=%h state=%0d run=%b alm=%b tick=%b, want all 0",
                     disp, state, running, alarm, tick);
        end
        reset = 1'b0;
        hold_inc(1'b1, 1'b0, 5);
        hold_inc(1'b0, 1'b1, 30);
        checks++;
        if (disp !== 16'h0530) begin
            errors++;
            $display("[TB] FAIL set_0530: got %h want 0530", disp);
        end
        pulse_start();
        wait_cycles(5);
        checks++;
        if (disp !== 16'h0529 || state !== 3'd1) begin
            errors++;
            $display("[TB] FAIL run_before_reset: got disp=%h state=%0d want 0529/1", disp, state);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({disp, state, running, alarm, tick} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got disp=%h state=%0d run=%b alm=%b tick=%b, want all 0",
                     disp, state, running, alarm, tick);
        end
        @(negedge clk_in);
        reset = 1'b0;
        begin
            int tickSeen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk_in);
                if (tick) tickSeen++;
            end
            checks++;
            if (tickSeen !== 0 || state !== 3'd0) begin
                errors++;
                $display("[TB] FAIL no_residual_tick: got ticks=%0d state=%0d want 0/0", tickSeen, state);
            end
        end
    endtask

    task automatic test_countdown();
        hold_inc(1'b1, 1'b0, 1);
        pulse_start();
        checks++;
        if (running !== 1'b1 || state !== 3'd1) begin
            errors++;
            $display("[TB] FAIL start_running: got run=%b state=%0d want 1/1", running, state);
        end
        wait_cycles(3);
        checks++;
        if (tick !== 1'b0 || disp !== 16'h0100) begin
            errors++;
            $display("[TB] FAIL pre_tick: got tick=%b disp=%h want 0/0100", tick, disp);
        end
        wait_cycles(1);
        checks++;
        if (tick !== 1'b1 || disp !== 16'h0059) begin
            errors++;
            $display("[TB] FAIL first_tick: got tick=%b disp=%h want 1/0059", tick, disp);
        end
        wait_cycles(1);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tick_width: got tick=%b want 0", tick);
        end
        wait_cycles(3);
        checks++;
        if (tick !== 1'b1 || disp !== 16'h0058) begin
            errors++;
            $display("[TB] FAIL second_tick: got tick=%b disp=%h want 1/0058", tick, disp);
        end
        pulse_clear();
        checks++;
        if (state !== 3'd0 || disp !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_run: got state=%0d disp=%h run=%b want 0/0000/0", state, disp, running);
        end
    endtask

    task automatic test_set_wrap();
        hold_inc(1'b0, 1'b1, 59);
        checks++;
        if (disp !== 16'h0059) begin
            errors++;
            $display("[TB] FAIL sec_59: got %h want 0059", disp);
        end
        hold_inc(1'b0, 1'b1, 1);
        checks++;
        if (disp !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL sec_wrap: got %h want 0000", disp);
        end
        hold_inc(1'b1, 1'b0, 99);
        checks++;
        if (disp !== 16'h9900) begin
            errors++;
            $display("[TB] FAIL min_99: got %h want 9900", disp);
        end
        hold_inc(1'b1, 1'b0, 1);
        checks++;
        if (disp !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL min_wrap: got %h want 0000", disp);
        end
        hold_inc(1'b1, 1'b1, 1);
        checks++;
        if (disp !== 16'h0101) begin
            errors++;
            $display("[TB] FAIL inc_both: got %h want 0101", disp);
        end
        pulse_clear();
    endtask

    task automatic test_alarm();
        int n;
        hold_inc(1'b0, 1'b1, 2);
        pulse_start();
        wait_cycles(4);
        checks++;
        if (disp !== 16'h0001 || state !== 3'd1) begin
            errors++;
            $display("[TB] FAIL alarm_first_tick: got disp=%h state=%0d want 0001/1", disp, state);
        end
        wait_cycles(4);
        checks++;
        if (state !== 3'd3 || alarm !== 1'b1 || running !== 1'b0 || disp !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL alarm_enter: got state=%0d alm=%b run=%b disp=%h want 3/1/0/0000",
                     state, alarm, running, disp);
        end
        n = 0;
        while (alarm === 1'b1 && n < 30) begin
            wait_cycles(1);
            n++;
        end
        checks++;
        if (n !== 12) begin
            errors++;
            $display("[TB] FAIL alarm_length: got %0d cycles want 12", n);
        end
        checks++;
        if (state !== 3'd0 || disp !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL alarm_exit: got state=%0d disp=%h want 0/0000", state, disp);
        end
    endtask

    task automatic test_pause();
        int tickSeen;
        hold_inc(1'b0, 1'b1, 10);
        pulse_start();
        pulse_start();
        checks++;
        if (state !== 3'd2 || running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pause_enter: got state=%0d run=%b want 2/0", state, running);
        end
        tickSeen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (tick) tickSeen++;
        end
        checks++;
        if (tickSeen !== 0 || disp !== 16'h0010 || state !== 3'd2) begin
            errors++;
            $display("[TB] FAIL pause_hold: got ticks=%0d disp=%h state=%0d want 0/0010/2",
                     tickSeen, disp, state);
        end
        pulse_start();
        wait_cycles(1);
        checks++;
        if (tick !== 1'b0 || disp !== 16'h0010) begin
            errors++;
            $display("[TB] FAIL resume_early: got tick=%b disp=%h want 0/0010", tick, disp);
        end
        wait_cycles(1);
        checks++;
        if (tick !== 1'b1 || disp !== 16'h0009) begin
            errors++;
            $display("[TB] FAIL resume_tick: got tick=%b disp=%h want 1/0009", tick, disp);
        end
        pulse_clear();
    endtask

    task automatic test_back_to_back();
        pulse_start();
        checks++;
        if (state !== 3'd0 || running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_at_zero: got state=%0d run=%b want 0/0", state, running);
        end
        hold_inc(1'b0, 1'b1, 5);
        pulse_start();
        wait_cycles(1);
        @(negedge clk_in);
        clear = 1'b1;
        start_stop = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
        start_stop = 1'b0;
        checks++;
        if (state !== 3'd0 || disp !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_priority: got state=%0d disp=%h run=%b want 0/0000/0",
                     state, disp, running);
        end
        hold_inc(1'b0, 1'b1, 1);
        pulse_start();
        wait_cycles(2);
        pulse_start();
        checks++;
        if (state !== 3'd3 || alarm !== 1'b1 || tick !== 1'b1 || disp !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL tick_stop_alarm: got state=%0d alm=%b tick=%b disp=%h want 3/1/1/0000",
                     state, alarm, tick, disp);
        end
        pulse_start();
        checks++;
        if (state !== 3'd0 || alarm !== 1'b0) begin
            errors++;
            $display("[TB] FAIL silence_alarm: got state=%0d alm=%b want 0/0", state, alarm);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        inc_min    = 1'b0;
        inc_sec    = 1'b0;
        #1;
        test_reset();
        test_countdown();
        test_set_wrap();
        test_alarm();
        test_pause();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
